// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: initiator side of a single-port byte-enable line memory.
// Takes scalar load/store requests, drives the memory port (splitting
// line-crossing accesses into two memory cycles when MEM_PORT_SPLIT_EN is
// defined) and returns extended load data or a store acknowledgement.
// Without MEM_PORT_SPLIT_EN a line-crossing access is answered with rsp_err.
module mem_port_ctrl #(
    parameter int DW = 128,
    parameter int AW = 16,
    localparam int OB = $clog2(DW / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [2:0]         req_funct3,
    input  logic [AW+OB-1:0]   req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               mem_en,
    output logic [DW/8-1:0]    mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);

    localparam int NB = DW / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_ACC1,
        S_DATA,
        S_RSP
    } state_t;

    state_t            state_q;
    logic [OB-1:0]     off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic              split_q;
    logic [DW-1:0]     line0_q;
    logic [NB-1:0]     hi_we_q;
    logic [DW-1:0]     hi_din_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic              mem_en_q;
    logic [NB-1:0]     mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_din_q;

    logic [OB-1:0]     req_off;
    logic [AW-1:0]     req_line;
    logic [3:0]        req_mask;
    logic [31:0]       req_wmask;
    logic [2*NB-1:0]   req_be_wide;
    logic [2*DW-1:0]   req_din_wide;
    logic              req_split;

    logic [2*DW-1:0]   rd_wide;
    logic [31:0]       rd_raw;
    logic [31:0]       load_data_d;
    logic [31:0]       rsp_rdata_d;

    assign req_off  = req_addr[OB-1:0];
    assign req_line = req_addr[AW+OB-1:OB];

    // Place the incoming request on a two-line-wide lane map: the low half
    // belongs to line0, the high half to the following line.
    always_comb begin
        // NOTE: every variable gets a default before any branch so the block
        // stays purely combinational (no latch is inferred).
        req_mask = 4'b1111;
        case (req_funct3[1:0])
            2'd0:    req_mask = 4'b0001;
            2'd1:    req_mask = 4'b0011;
            default: req_mask = 4'b1111;
        endcase
        req_wmask    = {{8{req_mask[3]}}, {8{req_mask[2]}}, {8{req_mask[1]}}, {8{req_mask[0]}}} & req_wdata;
        req_be_wide  = {{(2*NB-4){1'b0}}, req_mask} << req_off;
        req_din_wide = {{(2*DW-32){1'b0}}, req_wmask} << {req_off, 3'b000};
        req_split    = |req_be_wide[2*NB-1:NB];
    end

    // Extract and extend the load result from the captured line(s).
    always_comb begin
        rd_wide     = split_q ? {mem_dout, line0_q} : {{DW{1'b0}}, mem_dout};
        rd_raw      = 32'(rd_wide >> {off_q, 3'b000});
        load_data_d = rd_raw;
        case (size_q)
            2'd0:    load_data_d = {{24{~uns_q & rd_raw[7]}}, rd_raw[7:0]};
            2'd1:    load_data_d = {{16{~uns_q & rd_raw[15]}}, rd_raw[15:0]};
            default: load_data_d = rd_raw;
        endcase
        rsp_rdata_d = we_q ? 32'd0 : load_data_d;
    end

    // Request/access/response sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of its inputs.
            state_q     <= S_IDLE;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            line0_q     <= '0;
            hi_we_q     <= '0;
            hi_din_q    <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        off_q       <= req_off;
                        size_q      <= req_funct3[1:0];
                        uns_q       <= req_funct3[2];
                        we_q        <= req_we;
                        split_q     <= req_split;
                        hi_we_q     <= req_we ? req_be_wide[2*NB-1:NB] : '0;
                        hi_din_q    <= req_we ? req_din_wide[2*DW-1:DW] : '0;
                        if (req_funct3[1:0] == 2'd3) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= S_RSP;
                        end
`ifndef MEM_PORT_SPLIT_EN
                        else if (req_split) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                            state_q     <= S_RSP;
                        end
`endif
                        else begin
                            mem_en_q   <= 1'b1;
                            mem_addr_q <= req_line;
                            mem_we_q   <= req_we ? req_be_wide[NB-1:0] : '0;
                            mem_din_q  <= req_we ? req_din_wide[DW-1:0] : '0;
                            state_q    <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    if (split_q) begin
                        // Line address wraps naturally at 2^AW.
                        mem_addr_q <= mem_addr_q + 1'b1;
                        mem_we_q   <= hi_we_q;
                        mem_din_q  <= hi_din_q;
                        state_q    <= S_ACC1;
                    end else begin
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                        mem_we_q   <= '0;
                        mem_din_q  <= '0;
                        state_q    <= S_DATA;
                    end
                end
                S_ACC1: begin
                    line0_q    <= mem_dout;
                    mem_en_q   <= 1'b0;
                    mem_addr_q <= '0;
                    mem_we_q   <= '0;
                    mem_din_q  <= '0;
                    state_q    <= S_DATA;
                end
                S_DATA: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= rsp_rdata_d;
                    state_q     <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    mem_en_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_we_q    <= '0;
                    mem_din_q   <= '0;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: a byte-level reference memory predicts load data,
// error status, latency and the exact memory cycles of every request; a
// per-cycle monitor checks idle memory outputs and response stability.
module tb_mem_port_ctrl;

    localparam int DW  = 128;
    localparam int AW  = 16;
    localparam int NB  = 16;
`ifdef MEM_PORT_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
    localparam logic [19:0] RST_ADDR = 20'h0001E;
`else
    localparam bit SPLIT_EN = 1'b0;
    localparam logic [19:0] RST_ADDR = 20'h00024;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic           req_we = 1'b0;
    logic [2:0]     req_funct3 = 3'd0;
    logic [19:0]    req_addr = '0;
    logic [31:0]    req_wdata = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [31:0]    rsp_rdata;
    logic           rsp_err;
    logic           mem_en;
    logic [NB-1:0]  mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_din;
    logic [DW-1:0]  mem_dout = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Environment memory: line-organised, registered read, byte write enables.
    logic [DW-1:0] tb_mem [int];
    int wr_count = 0;
    always @(posedge clk) begin : mem_env
        logic [DW-1:0] line;
        if (mem_en) begin
            line = tb_mem.exists(int'(mem_addr)) ? tb_mem[int'(mem_addr)] : '0;
            mem_dout <= line;
            if (|mem_we) begin
                for (int b = 0; b < NB; b++)
                    if (mem_we[b]) line[b*8 +: 8] = mem_din[b*8 +: 8];
                tb_mem[int'(mem_addr)] = line;
                wr_count++;
            end
        end
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    task automatic preload(input int a, input logic [7:0] v);
        logic [DW-1:0] l;
        ref_mem[a] = v;
        l = tb_mem.exists(a >> 4) ? tb_mem[a >> 4] : '0;
        l[(a & 15)*8 +: 8] = v;
        tb_mem[a >> 4] = l;
    endtask

    // Monitor: records memory cycles and checks per-cycle invariants.
    typedef struct {
        logic [AW-1:0] addr;
        logic [NB-1:0] we;
        logic [DW-1:0] din;
    } acc_t;
    acc_t acc_q[$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic        prev_err   = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (mem_en) acc_q.push_back('{mem_addr, mem_we, mem_din});
            else check("mem_idle_zero", (mem_we == '0 && mem_addr == '0 && mem_din == '0), 1);
            if (rsp_valid) check("req_ready_during_rsp", req_ready, 0);
            if (prev_valid && !prev_ready) begin
                check("rsp_valid_held", rsp_valid, 1);
                check("rsp_rdata_held", rsp_rdata, prev_rdata);
                check("rsp_err_held", rsp_err, prev_err);
            end
            prev_valid = rsp_valid;
            prev_ready = rsp_ready;
            prev_rdata = rsp_rdata;
            prev_err   = rsp_err;
        end
    end

    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;

    // One full request/response transaction checked against the model.
    task automatic do_req(input string name, input logic we, input logic [2:0] f3,
                          input logic [19:0] addr, input logic [31:0] wdata, input int stall);
        int n, off, exp_lat, exp_cnt, a, idx, lat;
        bit split, err, seen;
        logic [15:0]  line_a;
        logic [15:0]  exp_addr [2];
        logic [15:0]  exp_we   [2];
        logic [127:0] exp_din  [2];
        logic [31:0]  exp_rdata;

        n      = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off    = int'(addr) & 15;
        split  = (off + n) > NB;
        err    = (f3[1:0] == 2'd3) || (split && !SPLIT_EN);
        line_a = addr[19:4];
        exp_addr[0] = line_a;
        exp_addr[1] = line_a + 16'd1;
        exp_we[0] = '0;  exp_we[1] = '0;
        exp_din[0] = '0; exp_din[1] = '0;
        exp_rdata = '0;
        if (!err) begin
            for (int k = 0; k < n; k++) begin
                a   = (int'(addr) + k) & 32'hFFFFF;
                idx = ((a >> 4) == int'(line_a)) ? 0 : 1;
                if (we) begin
                    exp_we[idx][a & 15] = 1'b1;
                    exp_din[idx][(a & 15)*8 +: 8] = wdata[k*8 +: 8];
                end else begin
                    exp_rdata[k*8 +: 8] = ref_rd(a);
                end
            end
            if (!we && !f3[2] && n < 4 && exp_rdata[8*n-1])
                exp_rdata = exp_rdata | (32'hFFFFFFFF << (8*n));
        end
        exp_lat = err ? 1 : (split ? 4 : 3);
        exp_cnt = err ? 0 : (split ? 2 : 1);

        acc_q.delete();
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        rsp_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check({name, "_req_ready"}, req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;

        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; lat = i; end
        end
        check({name, "_latency"}, lat, exp_lat);
        last_lat   = lat;
        last_rdata = rsp_rdata;
        last_err   = rsp_err;
        if (seen) begin
            check({name, "_rdata"}, rsp_rdata, exp_rdata);
            check({name, "_err"}, rsp_err, err);
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                check({name, "_stall_valid"}, rsp_valid, 1);
                check({name, "_stall_rdata"}, rsp_rdata, last_rdata);
                check({name, "_stall_ready"}, req_ready, 0);
            end
            @(posedge clk); #1 rsp_ready = 1'b1;
            @(posedge clk); #1 rsp_ready = 1'b0;
            @(negedge clk);
            check({name, "_rsp_done"}, rsp_valid, 0);
            check({name, "_ready_back"}, req_ready, 1);
        end

        check({name, "_acc_cnt"}, acc_q.size(), exp_cnt);
        for (int i = 0; i < acc_q.size() && i < 2; i++) begin
            check($sformatf("%s_acc%0d_addr", name, i), acc_q[i].addr, exp_addr[i]);
            check($sformatf("%s_acc%0d_we", name, i), acc_q[i].we, exp_we[i]);
            check($sformatf("%s_acc%0d_din", name, i), acc_q[i].din, exp_din[i]);
        end

        if (we && !err)
            for (int k = 0; k < n; k++) ref_mem[(int'(addr) + k) & 32'hFFFFF] = wdata[k*8 +: 8];
    endtask

    // Reset asserted while the first memory cycle of a store is on the port.
    task automatic reset_mid_access();
        int wr0;
        wr0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = RST_ADDR; req_wdata = 32'hAABBCCDD;
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #2;
        rst = 1'b1; req_valid = 1'b0;
        #1;
        check("rst_req_ready_now", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_write", wr_count, wr0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_rdata", rsp_rdata, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_mem_en", mem_en, 0);
        check("reset_mem_outs", {mem_we, mem_addr}, 0);
        rst = 1'b0;

        // Aligned word store then load.
        do_req("sw_aligned", 1'b1, 3'b010, 20'h00010, 32'hDEADBEEF, 0);
        check("sw_aligned_lit_cnt", acc_q.size(), 1);
        if (acc_q.size() > 0) begin
            check("sw_aligned_lit_addr", acc_q[0].addr, 16'h0001);
            check("sw_aligned_lit_we", acc_q[0].we, 16'h000F);
        end
        do_req("lw_aligned", 1'b0, 3'b010, 20'h00010, 32'h0, 0);
        check("lw_aligned_lit", last_rdata, 32'hDEADBEEF);
        check("lw_aligned_lit_lat", last_lat, 3);

        // Signed and unsigned byte.
        preload(5, 8'h80);
        do_req("lb", 1'b0, 3'b000, 20'h00005, 32'h0, 0);
        check("lb_lit", last_rdata, 32'hFFFFFF80);
        do_req("lbu", 1'b0, 3'b100, 20'h00005, 32'h0, 0);
        check("lbu_lit", last_rdata, 32'h00000080);

        // Misaligned half-word inside one line.
        preload(7, 8'h34);
        preload(8, 8'h12);
        do_req("lh_inline", 1'b0, 3'b001, 20'h00007, 32'h0, 0);
        check("lh_inline_lit", last_rdata, 32'h00001234);
        check("lh_inline_lit_cnt", acc_q.size(), 1);

        // More in-line patterns: negative half, last lane byte, misaligned word.
        preload(32'h40, 8'h80);
        preload(32'h41, 8'hFF);
        do_req("lh_neg", 1'b0, 3'b001, 20'h00040, 32'h0, 0);
        check("lh_neg_lit", last_rdata, 32'hFFFFFF80);
        do_req("lhu_neg", 1'b0, 3'b101, 20'h00040, 32'h0, 0);
        check("lhu_neg_lit", last_rdata, 32'h0000FF80);
        do_req("sb_lane15", 1'b1, 3'b000, 20'h0002F, 32'hFFFFFFA5, 0);
        do_req("lb_lane15", 1'b0, 3'b000, 20'h0002F, 32'h0, 0);
        do_req("sh_mis", 1'b1, 3'b001, 20'h00033, 32'h0000BEEF, 0);
        do_req("lw_mis", 1'b0, 3'b010, 20'h00032, 32'h0, 1);

        // Line-crossing word store and load.
        do_req("sw_split", 1'b1, 3'b010, 20'h0000E, 32'h11223344, 0);
`ifdef MEM_PORT_SPLIT_EN
        check("sw_split_lit_cnt", acc_q.size(), 2);
        if (acc_q.size() > 1) begin
            check("sw_split_lit_we0", acc_q[0].we, 16'hC000);
            check("sw_split_lit_addr1", acc_q[1].addr, 16'h0001);
            check("sw_split_lit_we1", acc_q[1].we, 16'h0003);
        end
        do_req("lw_split", 1'b0, 3'b010, 20'h0000E, 32'h0, 0);
        check("lw_split_lit", last_rdata, 32'h11223344);
        check("lw_split_lit_lat", last_lat, 4);
`else
        check("sw_split_lit_err", last_err, 1);
        check("sw_split_lit_lat", last_lat, 1);
        check("sw_split_lit_cnt", acc_q.size(), 0);
        do_req("lw_split", 1'b0, 3'b010, 20'h0000E, 32'h0, 0);
        check("lw_split_lit_rdata", last_rdata, 32'h0);
`endif
        do_req("lh_split", 1'b0, 3'b001, 20'h0001F, 32'h0, 0);

        // Address wrap with response backpressure.
        preload(32'hFFFFE, 8'h78);
        preload(32'hFFFFF, 8'h56);
        preload(32'h00000, 8'h34);
        preload(32'h00001, 8'h12);
        do_req("lw_wrap", 1'b0, 3'b010, 20'hFFFFE, 32'h0, 5);
`ifdef MEM_PORT_SPLIT_EN
        check("lw_wrap_lit", last_rdata, 32'h12345678);
        if (acc_q.size() > 1) check("lw_wrap_lit_addr1", acc_q[1].addr, 16'h0000);
`else
        check("lw_wrap_lit_err", last_err, 1);
`endif

        // Illegal size.
        do_req("ld_illegal", 1'b0, 3'b011, 20'h00020, 32'h0, 0);
        check("ld_illegal_lit_err", last_err, 1);
        check("ld_illegal_lit_cnt", acc_q.size(), 0);
        do_req("st_illegal", 1'b1, 3'b111, 20'h00020, 32'hCAFEF00D, 2);

        // Reset in the middle of an access, then confirm memory was not written.
        reset_mid_access();
        do_req("ld_after_rst", 1'b0, 3'b010, RST_ADDR, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
